// File: rtl/lh_pkg.sv
// lh_pkg: framing constants, FSM states and bit-rotate helper for the lh_aes_param hash.
package lh_pkg;
    localparam logic [7:0] HEAD = 8'hFF;
    localparam logic [7:0] TAIL = 8'h00;
    localparam logic [7:0] LO_A = 8'h20;
    localparam logic [7:0] HI_A = 8'h7E;
    localparam logic [7:0] LO_B = 8'hA1;
    localparam logic [7:0] HI_B = 8'hFE;

    typedef enum logic [1:0] {IDLE, ACCEPT, ROUND, DONE} state_t;

    function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic is_legal(input logic [7:0] x);
        return (x >= LO_A && x <= HI_A) || (x >= LO_B && x <= HI_B);
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box lookup.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [7:0] T [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = T[a];
endmodule

// File: rtl/lh_aes_param.sv
// lh_aes_param: framed byte-stream hash; each payload byte drives ROUNDS S-box rounds over NUM_BLOCKS chaining bytes.
module lh_aes_param
    import lh_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int ROUNDS = 32,
    parameter int MAX_LEN = 1024,
    parameter logic [7:0] IV = 8'h00
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [7:0] message_byte,
    input  logic message_valid,
    output logic message_ready,
    output logic [8*NUM_BLOCKS-1:0] digest,
    output logic digest_ready,
    input  logic digest_ack,
    output logic err_invalid_message_byte,
    output logic err_overflow
);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int RW = $clog2(ROUNDS + 1);

    state_t state;
    logic [7:0] h [NUM_BLOCKS];
    logic [7:0] nh [NUM_BLOCKS];
    logic [7:0] b;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rcnt;
    logic [8*NUM_BLOCKS-1:0] packed_h;
    logic acc;

    assign acc = message_valid && message_ready;

    for (genvar j = 0; j < NUM_BLOCKS; j++) begin : g_round
        aes_sbox u_sbox (
            .a(rotl8(h[(j + 2) % NUM_BLOCKS] ^ b, 3'(j % 8))),
            .y(nh[j])
        );
    end

    always_comb begin
        packed_h = '0;
        for (int i = 0; i < NUM_BLOCKS; i++)
            packed_h[8*(NUM_BLOCKS-i)-1 -: 8] = h[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            for (int i = 0; i < NUM_BLOCKS; i++)
                h[i] <= IV ^ 8'(i);
            b <= '0;
            cnt <= '0;
            rcnt <= '0;
            digest <= '0;
            digest_ready <= 1'b0;
            err_invalid_message_byte <= 1'b0;
            err_overflow <= 1'b0;
            message_ready <= 1'b0;
        end else begin
            err_invalid_message_byte <= 1'b0;
            err_overflow <= 1'b0;
            if (digest_ack)
                digest_ready <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    message_ready <= 1'b1;
                    if (acc && message_byte == HEAD) begin
                        for (int i = 0; i < NUM_BLOCKS; i++)
                            h[i] <= IV ^ 8'(i);
                        cnt <= '0;
                        digest_ready <= 1'b0;
                        state <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    message_ready <= 1'b1;
                    if (acc) begin
                        if (message_byte == HEAD) begin
                            for (int i = 0; i < NUM_BLOCKS; i++)
                                h[i] <= IV ^ 8'(i);
                            cnt <= '0;
                            digest_ready <= 1'b0;
                        end else if (message_byte == TAIL) begin
                            digest <= packed_h;
                            digest_ready <= 1'b1;
                            state <= DONE;
                        end else if (is_legal(message_byte) && cnt == CW'(MAX_LEN)) begin
                            err_overflow <= 1'b1;
                            state <= IDLE;
                        end else if (is_legal(message_byte)) begin
                            b <= message_byte;
                            cnt <= cnt + 1'b1;
                            message_ready <= 1'b0;
                            state <= ROUND;
                        end else begin
                            err_invalid_message_byte <= 1'b1;
                        end
                    end
                end
                ROUND: begin
                    for (int i = 0; i < NUM_BLOCKS; i++)
                        h[i] <= nh[i];
                    if (rcnt == RW'(ROUNDS - 1)) begin
                        rcnt <= '0;
                        message_ready <= 1'b1;
                        state <= ACCEPT;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lh_aes_param.sv
// tb_lh_aes_param: scoreboard bench over three parameterisations against a GF(2^8)-derived reference model.
module tb_lh_aes_param;
    import lh_pkg::*;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int k;
        logic [127:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [7:0] mb [3];
    logic mv [3];
    logic ack [3];
    logic rdy [3];
    logic dr [3];
    logic ei [3];
    logic eo [3];
    logic [63:0] dg0, dg1;
    logic [127:0] dg2;

    exp_t sb[$];
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_inv [3] = '{0, 0, 0};
    int n_ovf [3] = '{0, 0, 0};
    logic [7:0] sbt [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    lh_aes_param u0 (
        .clk(clk), .rst_n(rst_n), .message_byte(mb[0]), .message_valid(mv[0]), .message_ready(rdy[0]),
        .digest(dg0), .digest_ready(dr[0]), .digest_ack(ack[0]),
        .err_invalid_message_byte(ei[0]), .err_overflow(eo[0])
    );
    lh_aes_param #(.ROUNDS(1), .MAX_LEN(2)) u1 (
        .clk(clk), .rst_n(rst_n), .message_byte(mb[1]), .message_valid(mv[1]), .message_ready(rdy[1]),
        .digest(dg1), .digest_ready(dr[1]), .digest_ack(ack[1]),
        .err_invalid_message_byte(ei[1]), .err_overflow(eo[1])
    );
    lh_aes_param #(.NUM_BLOCKS(16), .ROUNDS(64)) u2 (
        .clk(clk), .rst_n(rst_n), .message_byte(mb[2]), .message_valid(mv[2]), .message_ready(rdy[2]),
        .digest(dg2), .digest_ready(dr[2]), .digest_ack(ack[2]),
        .err_invalid_message_byte(ei[2]), .err_overflow(eo[2])
    );

    function automatic logic [127:0] dgk(int k);
        return k == 0 ? {64'b0, dg0} : k == 1 ? {64'b0, dg1} : dg2;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            b = b >> 1;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] x, int n);
        logic [15:0] w;
        w = {8'h00, x} << n;
        return w[7:0] | w[15:8];
    endfunction

    function automatic logic legal(logic [7:0] x);
        return (x >= 8'h20 && x <= 8'h7e) || (x >= 8'ha1 && x <= 8'hfe);
    endfunction

    function automatic logic [7:0] rand_legal();
        int v;
        v = $urandom_range(0, 188);
        return v < 95 ? 8'(32 + v) : 8'(161 + v - 95);
    endfunction

    function automatic logic [7:0] rand_illegal();
        logic [7:0] x;
        do x = 8'($urandom_range(1, 254)); while (legal(x));
        return x;
    endfunction

    // chaining bytes start at i (IV = 0), every payload byte runs r rounds, digest lists H[0] first
    function automatic logic [127:0] model(int n, int r, bq_t p);
        logic [7:0] h [16];
        logic [7:0] t [16];
        logic [127:0] d;
        for (int i = 0; i < n; i++) h[i] = 8'(i);
        foreach (p[q])
            repeat (r) begin
                for (int j = 0; j < n; j++) t[j] = sbt[rotl(h[(j + 2) % n] ^ p[q], j % 8)];
                for (int j = 0; j < n; j++) h[j] = t[j];
            end
        d = '0;
        for (int i = 0; i < n; i++) d = (d << 8) | 128'(h[i]);
        return d;
    endfunction

    task automatic push(int k, logic [127:0] d);
        exp_t e;
        e.k = k;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic send(int k, logic [7:0] b, output int t);
        int w;
        w = 0;
        mb[k] = b;
        mv[k] = 1'b1;
        while (!rdy[k] && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (!rdy[k]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout dut%0d: ready got 0 expected 1", k);
        end
        @(negedge clk);
        t = cyc;
        mv[k] = 1'b0;
    endtask

    task automatic snd(int k, logic [7:0] b);
        int t;
        send(k, b, t);
    endtask

    task automatic wait_dr(int k, output int lat);
        lat = 0;
        while (!dr[k] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("digest_ready_wait", 128'(dr[k]), 1);
    endtask

    task automatic release_dg(int k, int hold);
        repeat (hold) @(negedge clk);
        ack[k] = 1'b1;
        @(negedge clk);
        ack[k] = 1'b0;
        chk("ack_release", 128'(dr[k]), 0);
    endtask

    for (genvar g = 0; g < 3; g++) begin : mon
        logic prev = 1'b0;
        logic [127:0] held = '0;
        exp_t e;
        always @(negedge clk) begin
            if (dr[g] && !prev) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_digest dut%0d: got %h expected none", g, dgk(g));
                end else begin
                    e = sb.pop_front();
                    chk("digest_dut", 128'(g), 128'(e.k));
                    chk("digest", dgk(g), e.d);
                    held = e.d;
                end
            end else if (dr[g]) begin
                chk("digest_hold", dgk(g), held);
            end
            prev = dr[g];
            if (ei[g]) n_inv[g]++;
            if (eo[g]) n_ovf[g]++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, lat, i0, o0, ni;
        logic [127:0] e;
        bq_t p;
        for (int k = 0; k < 3; k++) begin
            mv[k] = 1'b0;
            ack[k] = 1'b0;
            mb[k] = 8'h00;
        end
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
            sbt[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", 128'(rdy[k]), 0);
            chk("rst_digest_ready", 128'(dr[k]), 0);
            chk("rst_digest", dgk(k), 0);
            chk("rst_errors", 128'({ei[k], eo[k]}), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk("ready_after_reset", 128'(rdy[k]), 1);

        push(0, 128'h0001020304050607);
        snd(0, HEAD);
        send(0, TAIL, t1);
        wait_dr(0, lat);
        chk("tail_to_ready", 128'(lat), 0);
        release_dg(0, 3);

        p = '{8'h20};
        push(1, model(8, 1, p));
        snd(1, HEAD);
        send(1, 8'h20, t1);
        send(1, TAIL, t2);
        chk("ready_gap", 128'(t2 - t1), 2);
        wait_dr(1, lat);
        chk("h0_sbox22", 128'(dg1[63:56]), 8'h93);
        release_dg(1, 2);

        p = '{8'h61, 8'h62};
        push(0, model(8, 32, p));
        i0 = n_inv[0];
        snd(0, HEAD);
        snd(0, 8'h61);
        snd(0, 8'h07);
        @(negedge clk);
        chk("invalid_pulse", 128'(n_inv[0] - i0), 1);
        snd(0, 8'h62);
        snd(0, TAIL);
        wait_dr(0, lat);
        chk("invalid_total", 128'(n_inv[0] - i0), 1);
        release_dg(0, 4);

        e = model(8, 1, p);
        push(1, e);
        snd(1, HEAD);
        snd(1, 8'h61);
        snd(1, 8'h62);
        snd(1, TAIL);
        wait_dr(1, lat);
        release_dg(1, 2);
        o0 = n_ovf[1];
        snd(1, HEAD);
        snd(1, 8'h61);
        snd(1, 8'h62);
        snd(1, 8'h63);
        repeat (2) @(negedge clk);
        chk("overflow_pulse", 128'(n_ovf[1] - o0), 1);
        snd(1, 8'h07);
        snd(1, 8'h64);
        snd(1, TAIL);
        repeat (3) @(negedge clk);
        chk("overflow_digest_ready", 128'(dr[1]), 0);
        chk("overflow_digest_kept", 128'(dg1), e);
        chk("overflow_idle_no_errors", 128'(n_inv[1] + n_ovf[1] - o0), 1);

        i0 = n_inv[0] + n_inv[1] + n_inv[2];
        o0 = n_ovf[0] + n_ovf[1] + n_ovf[2];
        snd(0, HEAD);
        snd(0, 8'h61);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_ready", 128'(rdy[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_ready_back", 128'(rdy[0]), 1);
        push(0, 128'h0001020304050607);
        snd(0, HEAD);
        snd(0, TAIL);
        wait_dr(0, lat);
        chk("midreset_no_errors", 128'(n_inv[0] + n_inv[1] + n_inv[2] - i0 + n_ovf[0] + n_ovf[1] + n_ovf[2] - o0), 0);
        release_dg(0, 2);

        for (int f = 0; f < 2; f++) begin
            p = {};
            for (int q = 0; q < 200; q++) p.push_back(rand_legal());
            push(2, model(16, 64, p));
            i0 = n_inv[2];
            ni = 0;
            snd(2, HEAD);
            foreach (p[q]) begin
                if ($urandom_range(0, 19) == 0) begin
                    snd(2, rand_illegal());
                    ni++;
                end
                snd(2, p[q]);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            snd(2, TAIL);
            wait_dr(2, lat);
            chk("random_invalid_count", 128'(n_inv[2] - i0), 128'(ni));
            release_dg(2, $urandom_range(5, 20));
        end

        chk("scoreboard_drained", 128'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
